// File: rtl/mcdt_pkg.sv
// Shared types and constants for the MCDT arbitration path.
//   NCH         : number of requesting channels
//   DW          : data width per channel
//   arb_state_e : arbiter FSM state
//   chnl_id_t   : channel index as carried on mcdt_id_o
package mcdt_pkg;

    localparam int unsigned NCH  = 3;
    localparam int unsigned DW   = 32;
    localparam int unsigned ID_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef logic [ID_W-1:0] chnl_id_t;

endpackage

// File: rtl/mcdt_rr_sel.sv
// Round-robin selector: picks the first eligible channel after last_id.
//   elig     : eligible channel vector (N bits)
//   last_id  : channel granted most recently
//   any_o    : at least one channel is eligible
//   sel_id_o : winning channel (0 when any_o is low)
module mcdt_rr_sel
    import mcdt_pkg::*;
#(
    parameter int unsigned N = NCH
) (
    input  logic [N-1:0] elig,
    input  chnl_id_t     last_id,
    output logic         any_o,
    output chnl_id_t     sel_id_o
);

    chnl_id_t cand;

    // Walk the ring from farthest to nearest so the nearest eligible
    // channel after last_id is the final (winning) assignment.
    always_comb begin
        any_o    = |elig;
        sel_id_o = '0;
        cand     = '0;
        for (int i = int'(N); i >= 1; i--) begin
            cand = chnl_id_t'((int'(last_id) + i) % int'(N));
            if (elig[cand]) begin
                sel_id_o = cand;
            end
        end
    end

endmodule

// File: rtl/mcdt_rr_arbiter.sv
// Round-robin burst arbiter between the per-channel slave FIFOs and the
// shared MCDT output. Grants one channel at a time, pops up to BURST words
// from it, and forwards each popped word through a registered output stage.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous reset, active-high
//   req_i       : channel FIFO non-empty (head word valid on data_i)
//   data_i      : channel k head word at [k*DW +: DW]
//   en_i        : per-channel arbitration enable
//   pop_o       : one-hot FIFO pop, combinational
//   mcdt_data_o : registered output word
//   mcdt_val_o  : output word/id valid
//   mcdt_id_o   : source channel of the output word
//   busy_o      : arbiter is in GRANT
module mcdt_rr_arbiter #(
    parameter int unsigned NCH   = mcdt_pkg::NCH,
    parameter int unsigned DW    = mcdt_pkg::DW,
    parameter int unsigned BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH-1:0]    req_i,
    input  logic [NCH*DW-1:0] data_i,
    input  logic [NCH-1:0]    en_i,
    output logic [NCH-1:0]    pop_o,
    output logic [DW-1:0]     mcdt_data_o,
    output logic              mcdt_val_o,
    output logic [1:0]        mcdt_id_o,
    output logic              busy_o
);

    import mcdt_pkg::*;

    localparam int unsigned CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    arb_state_e       state;
    chnl_id_t         cur_id;
    chnl_id_t         last_id;
    chnl_id_t         sel_id;
    logic [CNT_W-1:0] cnt;
    logic [NCH-1:0]   elig;
    logic             any_elig;
    logic             cur_elig;

    assign elig     = req_i & en_i;
    assign cur_elig = elig[cur_id];
    assign busy_o   = (state == GRANT);

    mcdt_rr_sel #(
        .N(NCH)
    ) u_sel (
        .elig    (elig),
        .last_id (last_id),
        .any_o   (any_elig),
        .sel_id_o(sel_id)
    );

    // Pop the granted channel whenever it still has data and is enabled.
    always_comb begin
        pop_o = '0;
        if ((state == GRANT) && cur_elig) begin
            pop_o[cur_id] = 1'b1;
        end
    end

    // Arbitration FSM, burst counter and output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cur_id      <= '0;
            cnt         <= '0;
            last_id     <= chnl_id_t'(NCH - 1);
            mcdt_data_o <= '0;
            mcdt_val_o  <= 1'b0;
            mcdt_id_o   <= '0;
        end else begin
            mcdt_val_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        cur_id <= sel_id;
                        cnt    <= '0;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (cur_elig) begin
                        mcdt_data_o <= data_i[32'(cur_id) * DW +: DW];
                        mcdt_id_o   <= cur_id;
                        mcdt_val_o  <= 1'b1;
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            last_id <= cur_id;
                            state   <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        // Channel emptied or was disabled: dead cycle, re-arbitrate.
                        last_id <= cur_id;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcdt_rr_arbiter.sv
// Bench for mcdt_rr_arbiter: instance 0 uses BURST=4, instance 1 BURST=1.
// Both see identical FIFO contents, enables and reset; a channel-level model
// predicts pops and outputs for each instance every cycle.
module tb_mcdt_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  en;
    logic [2:0]  req   [2];
    logic [95:0] data  [2];
    logic [2:0]  pop   [2];
    logic [31:0] mdata [2];
    logic        mval  [2];
    logic [1:0]  mid   [2];
    logic        busy  [2];

    mcdt_rr_arbiter #(.NCH(3), .DW(32), .BURST(4)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .data_i(data[0]), .en_i(en),
        .pop_o(pop[0]), .mcdt_data_o(mdata[0]), .mcdt_val_o(mval[0]),
        .mcdt_id_o(mid[0]), .busy_o(busy[0])
    );

    mcdt_rr_arbiter #(.NCH(3), .DW(32), .BURST(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .data_i(data[1]), .en_i(en),
        .pop_o(pop[1]), .mcdt_data_o(mdata[1]), .mcdt_val_o(mval[1]),
        .mcdt_id_o(mid[1]), .busy_o(busy[1])
    );

    always #5 clk = ~clk;

    // FIFO contents, index u*3+k
    logic [31:0] fq [6][$];

    // channel-level model per instance
    bit          m_gr   [2];
    int          m_ch   [2];
    int          m_n    [2];
    int          m_last [2];
    bit          m_val  [2];
    logic [31:0] m_data [2];
    int          m_id   [2];
    logic [2:0]  e_now  [2];

    // observed output log per instance
    logic [1:0]  lid  [2][$];
    logic [31:0] ldat [2][$];
    int          lcyc [2][$];

    logic [2:0]  last_pop  [2];
    logic        last_busy [2];
    logic        last_val  [2];

    int checks;
    int errors;
    int cyc;
    bit started;

    function automatic bit has(logic [2:0] v, int k);
        return v[2'(k)];
    endfunction

    function automatic int burst_of(int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic int pending(int u);
        int s;
        s = 0;
        for (int k = 0; k < 3; k++) s += fq[u*3+k].size();
        return s;
    endfunction

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d actual=%h required=%h cycle=%0d", nm, u, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic [31:0] w);
        fq[k].push_back(w);
        fq[3+k].push_back(w);
    endtask

    task automatic drive_ports();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 3; k++) begin
                if (fq[u*3+k].size() > 0) begin
                    req[u][k]          = 1'b1;
                    data[u][k*32 +: 32] = fq[u*3+k][0];
                end else begin
                    req[u][k]          = 1'b0;
                    data[u][k*32 +: 32] = 32'h0;
                end
            end
            e_now[u] = req[u] & en;
        end
    endtask

    // Advance the model one clock edge; the FIFO head leaves whenever the
    // granted channel is eligible, reset or not.
    task automatic model_step(input int u);
        logic [31:0] head;
        bit          p;
        bit          f;
        int          c;
        p    = m_gr[u] && has(e_now[u], m_ch[u]);
        head = 32'h0;
        if (p) head = fq[u*3+m_ch[u]].pop_front();
        if (rst) begin
            m_gr[u] = 0; m_ch[u] = 0; m_n[u] = 0; m_last[u] = 2;
            m_val[u] = 0; m_data[u] = 32'h0; m_id[u] = 0;
        end else begin
            m_val[u] = 0;
            if (!m_gr[u]) begin
                f = 0;
                for (int i = 1; i <= 3; i++) begin
                    c = (m_last[u] + i) % 3;
                    if (!f && has(e_now[u], c)) begin
                        f = 1;
                        m_ch[u] = c;
                    end
                end
                if (f) begin
                    m_gr[u] = 1;
                    m_n[u]  = 0;
                end
            end else if (p) begin
                m_val[u]  = 1;
                m_data[u] = head;
                m_id[u]   = m_ch[u];
                m_n[u]++;
                if (m_n[u] == burst_of(u)) begin
                    m_gr[u]   = 0;
                    m_last[u] = m_ch[u];
                end
            end else begin
                m_gr[u]   = 0;
                m_last[u] = m_ch[u];
            end
        end
    endtask

    task automatic tick();
        logic [2:0] exp_pop;
        drive_ports();
        @(negedge clk);
        cyc++;
        for (int u = 0; u < 2; u++) begin
            last_pop[u]  = pop[u];
            last_busy[u] = busy[u];
            last_val[u]  = mval[u];
            if (started) begin
                exp_pop = (m_gr[u] && has(e_now[u], m_ch[u])) ? (3'b001 << m_ch[u]) : 3'b000;
                chk("pop", u, 32'(pop[u]), 32'(exp_pop));
                chk("busy", u, 32'(busy[u]), 32'(m_gr[u]));
                chk("val", u, 32'(mval[u]), 32'(m_val[u]));
                if (m_val[u]) begin
                    chk("data", u, mdata[u], m_data[u]);
                    chk("id", u, 32'(mid[u]), 32'(m_id[u]));
                end
            end
            if (mval[u] === 1'b1) begin
                lid[u].push_back(mid[u]);
                ldat[u].push_back(mdata[u]);
                lcyc[u].push_back(cyc);
            end
        end
        @(posedge clk);
        for (int u = 0; u < 2; u++) model_step(u);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        for (int u = 0; u < 2; u++) begin
            lid[u].delete();
            ldat[u].delete();
            lcyc[u].delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 3'b111;
        for (int i = 0; i < 6; i++) fq[i].delete();
        tick();
        started = 1;
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic chk_drained(input string nm);
        for (int u = 0; u < 2; u++) chk(nm, u, 32'(pending(u)), 32'd0);
    endtask

    task automatic chk_span(input string nm, input int u, input int n, input int span);
        chk({nm, "_count"}, u, 32'(lid[u].size()), 32'(n));
        if (lid[u].size() == n) chk(nm, u, 32'(lcyc[u][n-1] - lcyc[u][0]), 32'(span));
    endtask

    initial begin
        bit found;
        clk     = 1'b0;
        rst     = 1'b1;
        en      = 3'b111;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        started = 0;
        for (int u = 0; u < 2; u++) begin
            req[u]  = 3'b000;
            data[u] = 96'h0;
        end

        // reset state
        do_reset();
        for (int u = 0; u < 2; u++) begin
            chk("rst_busy", u, 32'(last_busy[u]), 32'd0);
            chk("rst_val", u, 32'(last_val[u]), 32'd0);
            chk("rst_pop", u, 32'(last_pop[u]), 32'd0);
            chk("rst_id", u, 32'(mid[u]), 32'd0);
        end

        // ch0 only, 10 words
        do_reset();
        for (int i = 0; i < 10; i++) push(0, 32'h00C0_0000 + 32'(i));
        run(40);
        chk_drained("t1_drain");
        chk_span("t1_span", 0, 10, 11);
        chk_span("t1_span", 1, 10, 18);
        if (ldat[0].size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                chk("t1_data", 0, ldat[0][i], 32'h00C0_0000 + 32'(i));
                chk("t1_id", 0, 32'(lid[0][i]), 32'd0);
            end
            chk("t1_gap4", 0, 32'(lcyc[0][4] - lcyc[0][3]), 32'd2);
            chk("t1_gap8", 0, 32'(lcyc[0][8] - lcyc[0][7]), 32'd2);
            chk("t1_run", 0, 32'(lcyc[0][3] - lcyc[0][0]), 32'd3);
        end

        // all channels, 8 words each
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) push(k, $urandom);
        run(70);
        chk_drained("t2_drain");
        chk_span("t2_span", 0, 24, 28);
        chk_span("t2_span", 1, 24, 46);
        for (int u = 0; u < 2; u++) begin
            if (lid[u].size() == 24) begin
                for (int i = 0; i < 24; i++)
                    chk("t2_id", u, 32'(lid[u][i]), (u == 0) ? 32'((i / 4) % 3) : 32'(i % 3));
            end
        end

        // ch1 short, ch2 four, ch0 empty
        do_reset();
        for (int i = 0; i < 2; i++) push(1, 32'h0011_0000 + 32'(i));
        for (int i = 0; i < 4; i++) push(2, 32'h0022_0000 + 32'(i));
        run(30);
        chk_drained("t3_drain");
        chk("t3_count", 0, 32'(lid[0].size()), 32'd6);
        if (lid[0].size() == 6) begin
            for (int i = 0; i < 6; i++) chk("t3_id", 0, 32'(lid[0][i]), (i < 2) ? 32'd1 : 32'd2);
            chk("t3_gap", 0, 32'(lcyc[0][2] - lcyc[0][1]), 32'd3);
        end

        // ch1 disabled
        do_reset();
        en = 3'b101;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) push(k, $urandom);
        run(50);
        chk("t4_ch1_left", 0, 32'(fq[1].size()), 32'd8);
        chk("t4_ch1_left", 1, 32'(fq[4].size()), 32'd8);
        chk("t4_count", 0, 32'(lid[0].size()), 32'd16);
        if (lid[0].size() == 16) begin
            for (int i = 0; i < 16; i++)
                chk("t4_id", 0, 32'(lid[0][i]), ((i / 4) % 2 == 0) ? 32'd0 : 32'd2);
        end

        // reset in the middle of a ch1 burst
        do_reset();
        for (int i = 0; i < 8; i++) push(1, $urandom);
        found = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (last_pop[0] == 3'b010) begin
                found = 1;
                break;
            end
        end
        chk("t5_wait", 0, 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        chk("t5_second_pop", 0, 32'(last_pop[0]), 32'b010);
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) push(k, $urandom);
        tick();
        chk("t5_pop", 0, 32'(last_pop[0]), 32'd0);
        chk("t5_val", 0, 32'(last_val[0]), 32'd0);
        chk("t5_busy", 0, 32'(last_busy[0]), 32'd0);
        rst = 1'b0;
        clear_logs();
        run(30);
        for (int u = 0; u < 2; u++)
            chk("t5_first_id", u, (lid[u].size() > 0) ? 32'(lid[u][0]) : 32'd3, 32'd0);

        // randomized traffic, enables and resets
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) push($urandom_range(0, 2), $urandom);
            if ($urandom_range(0, 15) == 0) en = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 127) == 0);
            tick();
        end
        rst = 1'b0;
        en  = 3'b111;
        run(200);
        chk_drained("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
